// File: rtl/fu_pipe.sv
`timescale 1ns/1ps
// fu_pipe -- pipelined functional unit with valid/ready handshakes.
//
// Takes one op and operand pair per accepted cycle and returns the result and
// the Z/N/C/V flags STAGES cycles later. The result is computed in stage 1 as
// the op is accepted. Stages 2..STAGES only delay it. Backpressure from the
// consumer ripples back through the stages, so an op is never dropped and
// never repeated. ADC and SBC read an internal carry register. ADD, SUB, ADC,
// SBC and the three shifts write that register when they are accepted.
//
// Optional feature: define FU_PIPE_SAT_EN to enable op 12 (ADDS) and op 13
// (SUBS), signed saturating add and subtract. When it is not defined, both
// opcodes decode as illegal.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   in_valid / in_ready       input handshake for op, data_a, data_b
//   op [OPSIZE]               opcode
//   data_a, data_b [DSIZE]    operands
//   out_valid / out_ready     output handshake for F_o and the flags
//   F_o [DSIZE]               result
//   Z_o, N_o, C_o, V_o        zero, negative, carry/no-borrow, signed overflow
module fu_pipe #(
    parameter int DSIZE  = 16,
    parameter int OPSIZE = 5,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPSIZE-1:0] op,
    input  logic [DSIZE-1:0]  data_a,
    input  logic [DSIZE-1:0]  data_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DSIZE-1:0]  F_o,
    output logic              Z_o,
    output logic              N_o,
    output logic              C_o,
    output logic              V_o
);

    localparam int PW = DSIZE + 4;

    localparam logic [OPSIZE-1:0] OP_ADD  = OPSIZE'(0);
    localparam logic [OPSIZE-1:0] OP_SUB  = OPSIZE'(1);
    localparam logic [OPSIZE-1:0] OP_AND  = OPSIZE'(2);
    localparam logic [OPSIZE-1:0] OP_OR   = OPSIZE'(3);
    localparam logic [OPSIZE-1:0] OP_XOR  = OPSIZE'(4);
    localparam logic [OPSIZE-1:0] OP_NOT  = OPSIZE'(5);
    localparam logic [OPSIZE-1:0] OP_SHL  = OPSIZE'(6);
    localparam logic [OPSIZE-1:0] OP_SHR  = OPSIZE'(7);
    localparam logic [OPSIZE-1:0] OP_SRA  = OPSIZE'(8);
    localparam logic [OPSIZE-1:0] OP_PASS = OPSIZE'(9);
    localparam logic [OPSIZE-1:0] OP_ADC  = OPSIZE'(10);
    localparam logic [OPSIZE-1:0] OP_SBC  = OPSIZE'(11);
`ifdef FU_PIPE_SAT_EN
    localparam logic [OPSIZE-1:0] OP_ADDS = OPSIZE'(12);
    localparam logic [OPSIZE-1:0] OP_SUBS = OPSIZE'(13);
    localparam logic [DSIZE-1:0]  SAT_MAX = {1'b0, {(DSIZE-1){1'b1}}};
    localparam logic [DSIZE-1:0]  SAT_MIN = {1'b1, {(DSIZE-1){1'b0}}};
`endif

    logic              r_cr;
    logic              r_rst_done;
    logic [STAGES-1:0] r_valid;
    logic [PW-1:0]     r_data [STAGES];

    logic              w_accept;
    logic [STAGES-1:0] w_adv;
    logic              w_sub;
    logic              w_cin;
    logic [DSIZE-1:0]  w_opb;
    logic [DSIZE:0]    w_sum;
    logic              w_ovf;
    logic [3:0]        w_shamt;
    logic [DSIZE:0]    w_shl;
    logic [DSIZE:0]    w_shr;
    logic [DSIZE:0]    w_sra;
    logic [DSIZE-1:0]  w_f;
    logic              w_c;
    logic              w_v;
    logic              w_cr_upd;
    logic [PW-1:0]     w_res;

    // One shared adder. Subtraction adds ~B plus a carry-in, so the carry out
    // reads as "no borrow".
    always_comb begin
        w_sub = 1'b0;
        w_cin = 1'b0;
        case (op)
            OP_SUB:  begin w_sub = 1'b1; w_cin = 1'b1; end
            OP_ADC:  w_cin = r_cr;
            OP_SBC:  begin w_sub = 1'b1; w_cin = r_cr; end
`ifdef FU_PIPE_SAT_EN
            OP_SUBS: begin w_sub = 1'b1; w_cin = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign w_opb = w_sub ? ~data_b : data_b;
    assign w_sum = {1'b0, data_a} + {1'b0, w_opb} + {{DSIZE{1'b0}}, w_cin};
    assign w_ovf = (data_a[DSIZE-1] == w_opb[DSIZE-1]) &&
                   (w_sum[DSIZE-1] != data_a[DSIZE-1]);

    // An extra guard bit on each shift catches the last bit shifted out. With
    // a shift amount of zero that bit is the zero padding.
    assign w_shamt = data_b[3:0];
    assign w_shl   = {1'b0, data_a} << w_shamt;
    assign w_shr   = {data_a, 1'b0} >> w_shamt;
    assign w_sra   = $signed({data_a, 1'b0}) >>> w_shamt;

    always_comb begin
        w_f      = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_cr_upd = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                w_f      = w_sum[DSIZE-1:0];
                w_c      = w_sum[DSIZE];
                w_v      = w_ovf;
                w_cr_upd = 1'b1;
            end
            OP_AND:  w_f = data_a & data_b;
            OP_OR:   w_f = data_a | data_b;
            OP_XOR:  w_f = data_a ^ data_b;
            OP_NOT:  w_f = ~data_a;
            OP_PASS: w_f = data_b;
            OP_SHL: begin
                w_f      = w_shl[DSIZE-1:0];
                w_c      = w_shl[DSIZE];
                w_cr_upd = 1'b1;
            end
            OP_SHR: begin
                w_f      = w_shr[DSIZE:1];
                w_c      = w_shr[0];
                w_cr_upd = 1'b1;
            end
            OP_SRA: begin
                w_f      = w_sra[DSIZE:1];
                w_c      = w_sra[0];
                w_cr_upd = 1'b1;
            end
`ifdef FU_PIPE_SAT_EN
            // Saturating ops report the raw carry but leave the carry register alone.
            OP_ADDS, OP_SUBS: begin
                w_f = w_ovf ? (data_a[DSIZE-1] ? SAT_MIN : SAT_MAX) : w_sum[DSIZE-1:0];
                w_c = w_sum[DSIZE];
                w_v = w_ovf;
            end
`endif
            default: ;
        endcase
    end

    assign w_res = {w_f, (w_f == '0), w_f[DSIZE-1], w_c, w_v};

    // A stage may advance when it is empty or when the stage after it advances.
    always_comb begin
        logic [STAGES-1:0] adv;
        adv = '0;
        adv[STAGES-1] = !r_valid[STAGES-1] || out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = !r_valid[i] || adv[i+1];
        end
        w_adv = adv;
    end

    // in_ready stays low until the first clock edge after reset is released.
    assign in_ready = r_rst_done && w_adv[0];
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cr       <= 1'b0;
            r_rst_done <= 1'b0;
            r_valid    <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_rst_done <= 1'b1;
            if (w_accept && w_cr_upd) begin
                r_cr <= w_c;
            end
            if (w_adv[0]) begin
                r_valid[0] <= w_accept;
                if (w_accept) begin
                    r_data[0] <= w_res;
                end
            end
            // Data is copied only behind a valid entry. A bubble clears valid
            // but leaves the last result on the outputs.
            for (int i = 1; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
        end
    end

    assign out_valid                = r_valid[STAGES-1];
    assign {F_o, Z_o, N_o, C_o, V_o} = r_data[STAGES-1];

endmodule

// File: tb/tb_fu_pipe.sv
`timescale 1ns/1ps
module tb_fu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  op = '0;
    logic [15:0] data_a = '0;
    logic [15:0] data_b = '0;

    logic rdy2, ov2, z2, n2, c2, v2; logic [15:0] f2;
    logic rdy1, ov1, z1, n1, c1, v1; logic [15:0] f1;
    logic rdy4, ov4, z4, n4, c4, v4; logic [15:0] f4;

    always #5 clk = ~clk;

    fu_pipe #(.DSIZE(16), .OPSIZE(5), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .op(op),
        .data_a(data_a), .data_b(data_b), .out_valid(ov2), .out_ready(out_ready),
        .F_o(f2), .Z_o(z2), .N_o(n2), .C_o(c2), .V_o(v2));

    fu_pipe #(.DSIZE(16), .OPSIZE(5), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .op(op),
        .data_a(data_a), .data_b(data_b), .out_valid(ov1), .out_ready(out_ready),
        .F_o(f1), .Z_o(z1), .N_o(n1), .C_o(c1), .V_o(v1));

    fu_pipe #(.DSIZE(16), .OPSIZE(5), .STAGES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .op(op),
        .data_a(data_a), .data_b(data_b), .out_valid(ov4), .out_ready(out_ready),
        .F_o(f4), .Z_o(z4), .N_o(n4), .C_o(c4), .V_o(v4));

    typedef struct { logic [4:0] op; logic [15:0] a; logic [15:0] b; int step; } acc_t;
    typedef struct { logic [19:0] r; int step; } cap_t;

    acc_t acc2[$], acc1[$], acc4[$];
    cap_t cap2[$], cap1[$], cap4[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic mcr2 = 1'b0;

    // Reference model: returns {new carry reg, F, Z, N, C, V}.
    function automatic logic [20:0] model(input logic [4:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic cr);
        int ua, ub, sa, sb, r, sr, k, x;
        logic [15:0] f;
        logic c, v, ncr;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        k = int'(b[3:0]);
        f = '0; c = 1'b0; v = 1'b0; ncr = cr;
        case (o)
            5'd0, 5'd10: begin
                x = (o == 5'd10) ? int'(cr) : 0;
                r = ua + ub + x; sr = sa + sb + x;
                f = r[15:0]; c = (r > 65535); v = (sr > 32767) || (sr < -32768); ncr = c;
            end
            5'd1, 5'd11: begin
                x = (o == 5'd11) ? int'(!cr) : 0;
                r = ua - ub - x; sr = sa - sb - x;
                f = r[15:0]; c = (r >= 0); v = (sr > 32767) || (sr < -32768); ncr = c;
            end
            5'd2: f = a & b;
            5'd3: f = a | b;
            5'd4: f = a ^ b;
            5'd5: f = ~a;
            5'd9: f = b;
            5'd6: begin f = a; for (int i = 0; i < k; i++) begin c = f[15]; f = {f[14:0], 1'b0}; end ncr = c; end
            5'd7: begin f = a; for (int i = 0; i < k; i++) begin c = f[0]; f = {1'b0, f[15:1]}; end ncr = c; end
            5'd8: begin f = a; for (int i = 0; i < k; i++) begin c = f[0]; f = {f[15], f[15:1]}; end ncr = c; end
`ifdef FU_PIPE_SAT_EN
            5'd12, 5'd13: begin
                sr = (o == 5'd12) ? sa + sb : sa - sb;
                c  = (o == 5'd12) ? (ua + ub > 65535) : (ua >= ub);
                if (sr > 32767) begin f = 16'h7FFF; v = 1'b1; end
                else if (sr < -32768) begin f = 16'h8000; v = 1'b1; end
                else f = sr[15:0];
            end
`endif
            default: ;
        endcase
        return {ncr, f, (f == 16'h0000), f[15], c, v};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drive(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b, input logic vld);
        op = o; data_a = a; data_b = b; in_valid = vld;
    endtask

    // Called at a negedge after the inputs are set. Records which transfers
    // happen at the next posedge, then moves on to the following negedge.
    task automatic cycle();
        #1;
        if (in_valid && rdy2) acc2.push_back('{op: op, a: data_a, b: data_b, step: cyc});
        if (in_valid && rdy1) acc1.push_back('{op: op, a: data_a, b: data_b, step: cyc});
        if (in_valid && rdy4) acc4.push_back('{op: op, a: data_a, b: data_b, step: cyc});
        if (ov2 && out_ready) cap2.push_back('{r: {f2, z2, n2, c2, v2}, step: cyc});
        if (ov1 && out_ready) cap1.push_back('{r: {f1, z1, n1, c1, v1}, step: cyc});
        if (ov4 && out_ready) cap4.push_back('{r: {f4, z4, n4, c4, v4}, step: cyc});
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        acc2.delete(); acc1.delete(); acc4.delete();
        cap2.delete(); cap1.delete(); cap4.delete();
        mcr2 = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ov2, f2, z2, n2, c2, v2} !== 21'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", {ov2, f2, z2, n2, c2, v2});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", rdy2); end
        out_ready = 1'b1;
        drive(5'd0, 16'hFFFF, 16'h0001, 1'b1); cycle();
        drive(5'd2, 16'h1234, 16'h00FF, 1'b1); cycle();
        drive(5'd4, 16'hAAAA, 16'h5555, 1'b1); cycle();
        in_valid = 1'b0;
        n_tests++;
        if (ov2 !== 1'b1) begin n_fail++; $display("FAIL reset_inflight: out_valid got %b required 1", ov2); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ov2, f2} !== 17'h0) begin
            n_fail++; $display("FAIL reset_async: out_valid/F got %h required 0", {ov2, f2});
        end
        apply_reset();
        repeat (4) cycle();
        n_tests++;
        if (cap2.size() != 0) begin n_fail++; $display("FAIL reset_stale: got %0d outputs required 0", cap2.size()); end
        drive(5'd10, 16'h0000, 16'h0000, 1'b1); cycle();
        in_valid = 1'b0;
        repeat (4) cycle();
        n_tests++;
        if (cap2.size() != 1 || cap2[0].r !== {16'h0000, 4'b1000}) begin
            n_fail++; $display("FAIL reset_carry: got %0d outputs first %h required 1 output 00008", cap2.size(),
                               (cap2.size() > 0) ? cap2[0].r : 20'h0);
        end
        acc2.delete(); cap2.delete(); mcr2 = 1'b0;
    endtask

    task automatic test_directed();
        logic [4:0]  o [7];
        logic [15:0] a [7];
        logic [15:0] b [7];
        logic [19:0] e [7];
        o[0] = 5'd0;  a[0] = 16'h7FFF; b[0] = 16'h0001; e[0] = {16'h8000, 4'b0101};
        o[1] = 5'd1;  a[1] = 16'h0005; b[1] = 16'h0005; e[1] = {16'h0000, 4'b1010};
        o[2] = 5'd0;  a[2] = 16'hFFFF; b[2] = 16'h0001; e[2] = {16'h0000, 4'b1010};
        o[3] = 5'd10; a[3] = 16'h0000; b[3] = 16'h0000; e[3] = {16'h0001, 4'b0000};
        o[4] = 5'd12; a[4] = 16'h7000; b[4] = 16'h2000;
        o[5] = 5'd13; a[5] = 16'h8000; b[5] = 16'h0001;
`ifdef FU_PIPE_SAT_EN
        e[4] = {16'h7FFF, 4'b0001};
        e[5] = {16'h8000, 4'b0111};
`else
        e[4] = {16'h0000, 4'b1000};
        e[5] = {16'h0000, 4'b1000};
`endif
        o[6] = 5'd10; a[6] = 16'h0000; b[6] = 16'h0000; e[6] = {16'h0000, 4'b1000};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(o[i], a[i], b[i], 1'b1); cycle();
        end
        in_valid = 1'b0;
        repeat (4) cycle();
        n_tests++;
        if (cap2.size() != 7) begin n_fail++; $display("FAIL directed_count: got %0d required 7", cap2.size()); end
        for (int i = 0; i < 7 && i < cap2.size(); i++) begin
            n_tests++;
            if (cap2[i].r !== e[i]) begin
                n_fail++; $display("FAIL directed_%0d: got %h required %h", i, cap2[i].r, e[i]);
            end
        end
        acc2.delete(); cap2.delete(); mcr2 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [19:0] held, exp;
        logic        have, stable;
        acc_t        ac;
        cap_t        cp;
        int          s0;
        have = 1'b0; stable = 1'b1; held = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(5'($urandom_range(0, 11)), rnd16(), rnd16(), 1'b1); cycle();
            if (ov2) begin
                if (!have) begin held = {f2, z2, n2, c2, v2}; have = 1'b1; end
                else if ({f2, z2, n2, c2, v2} !== held) stable = 1'b0;
            end
        end
        n_tests++;
        if (acc2.size() != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d required 2", acc2.size()); end
        n_tests++;
        if (!have || !stable) begin n_fail++; $display("FAIL bp_stable: valid %b stable %b required 1 1", have, stable); end
        out_ready = 1'b1;
        drive(5'($urandom_range(0, 11)), rnd16(), rnd16(), 1'b1); cycle();
        n_tests++;
        if (acc2.size() != 3 || cap2.size() != 1) begin
            n_fail++; $display("FAIL bp_drain_accept: accepts %0d outputs %0d required 3 1", acc2.size(), cap2.size());
        end
        in_valid = 1'b0;
        repeat (5) cycle();
        n_tests++;
        if (cap2.size() != 3) begin n_fail++; $display("FAIL bp_outputs: got %0d required 3", cap2.size()); end
        s0 = (cap2.size() > 0) ? cap2[0].step : 0;
        for (int i = 1; i < cap2.size(); i++) begin
            n_tests++;
            if (cap2[i].step != s0 + i) begin
                n_fail++; $display("FAIL bp_consecutive: output %0d step %0d required %0d", i, cap2[i].step, s0 + i);
            end
        end
        while (acc2.size() > 0) begin
            ac = acc2.pop_front();
            {mcr2, exp} = model(ac.op, ac.a, ac.b, mcr2);
            n_tests++;
            if (cap2.size() == 0) begin n_fail++; $display("FAIL bp_value: got none required %h", exp); end
            else begin
                cp = cap2.pop_front();
                if (cp.r !== exp) begin n_fail++; $display("FAIL bp_value: op %0d got %h required %h", ac.op, cp.r, exp); end
            end
        end
        cap2.delete();
    endtask

    task automatic test_random();
        logic [19:0] exp;
        acc_t        ac;
        cap_t        cp;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            drive(5'($urandom_range(0, 16)), rnd16(), rnd16(), ($urandom_range(0, 9) < 7));
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) cycle();
        while (acc2.size() > 0) begin
            ac = acc2.pop_front();
            {mcr2, exp} = model(ac.op, ac.a, ac.b, mcr2);
            n_tests++;
            if (cap2.size() == 0) begin n_fail++; $display("FAIL rand_value: got none required %h", exp); end
            else begin
                cp = cap2.pop_front();
                if (cp.r !== exp) begin
                    n_fail++; $display("FAIL rand_value: op %0d a %h b %h got %h required %h", ac.op, ac.a, ac.b, cp.r, exp);
                end
            end
        end
        n_tests++;
        if (cap2.size() != 0) begin n_fail++; $display("FAIL rand_extra: got %0d extra outputs required 0", cap2.size()); end
        cap2.delete();
    endtask

    task automatic test_latency();
        acc_t        a[$];
        cap_t        c[$];
        int          s;
        logic        cr;
        logic [19:0] exp;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(5'($urandom_range(0, 11)), rnd16(), rnd16(), 1'b1); cycle();
        end
        in_valid = 1'b0;
        repeat (8) cycle();
        for (int d = 0; d < 3; d++) begin
            case (d)
                0:       begin a = acc1; c = cap1; s = 1; end
                1:       begin a = acc2; c = cap2; s = 2; end
                default: begin a = acc4; c = cap4; s = 4; end
            endcase
            n_tests++;
            if (a.size() != 8 || c.size() != 8) begin
                n_fail++; $display("FAIL lat_count_s%0d: accepts %0d outputs %0d required 8 8", s, a.size(), c.size());
            end
            cr = 1'b0;
            for (int i = 0; i < 8 && i < a.size() && i < c.size(); i++) begin
                {cr, exp} = model(a[i].op, a[i].a, a[i].b, cr);
                n_tests++;
                if (a[i].step != a[0].step + i || c[i].step != a[i].step + s || c[i].r !== exp) begin
                    n_fail++;
                    $display("FAIL lat_s%0d_%0d: acc step %0d out step %0d value %h required acc %0d out %0d value %h",
                             s, i, a[i].step, c[i].step, c[i].r, a[0].step + i, a[i].step + s, exp);
                end
            end
        end
        acc2.delete(); acc1.delete(); acc4.delete();
        cap2.delete(); cap1.delete(); cap4.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
